// File: rtl/display_pkg.sv
// display_pkg
// Shared constants for the multiplexed seven-segment display controller:
// default geometry (digit count, scan divider), the ten digit patterns in
// {a,b,c,d,e,f,g,dp} order with dp cleared, the all-off pattern, and a
// helper that maps a BCD code onto its a..g segment bits.
package display_pkg;

    localparam int DEF_N_DIG    = 4;
    localparam int DEF_SCAN_DIV = 50000;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Returns segments a..g (bit 6 = a); non-decimal codes give all off.
    function automatic logic [6:0] seg_of(input logic [3:0] code);
        logic [7:0] pat;
        pat = SEG_BLANK;
        case (code)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat[7:1];
    endfunction

endpackage

// File: rtl/bcd_seg_dec.sv
// bcd_seg_dec
// Purely combinational BCD to seven-segment decoder.
// Ports:
//   code  in   4  BCD digit code (10..15 decode to all segments off)
//   segs  out  7  segments {a,b,c,d,e,f,g}, active-high
module bcd_seg_dec
    import display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] segs
);

    always_comb begin
        segs = seg_of(code);
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexed seven-segment display controller. A prescaler holds each
// digit selected for SCAN_DIV clocks; new values arrive over a valid/ready
// handshake into a one-entry pending buffer and are only committed to the
// display register at the end of a full scan, so a frame never tears.
// Ports:
//   clk         in   1        clock, rising edge
//   rst_n       in   1        synchronous active-low reset
//   upd_valid   in   1        new display value offered
//   upd_ready   out  1        no value pending, offer will be taken
//   upd_bcd     in   4*N_DIG  BCD digits, digit 0 in bits [3:0]
//   upd_dp      in   N_DIG    decimal-point mask, bit i for digit i
//   seg         out  8        {a,b,c,d,e,f,g,dp}, active-high
//   an          out  N_DIG    one-hot digit select, active-high
//   frame_tick  out  1        one-cycle pulse after each scan wrap
// Build option: define DISPLAY_BLANK_LZ_EN to blank leading zero digits
// (segments a..g off above the most significant nonzero digit; DP and
// digit 0 unaffected).
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIG    = DEF_N_DIG,
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [4*N_DIG-1:0] upd_bcd,
    input  logic [N_DIG-1:0]   upd_dp,
    output logic [7:0]         seg,
    output logic [N_DIG-1:0]   an,
    output logic               frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIG);

    logic [PW-1:0]      presc;
    logic [IW-1:0]      idx;
    logic               pending;
    logic [4*N_DIG-1:0] pend_bcd;
    logic [N_DIG-1:0]   pend_dp;
    logic [4*N_DIG-1:0] disp_bcd;
    logic [N_DIG-1:0]   disp_dp;

    logic               step;
    logic               wrap;
    logic [3:0]         cur_code;
    logic [6:0]         cur_segs;
    logic [N_DIG-1:0]   blank_lz;

    assign step      = (presc == PW'(SCAN_DIV - 1));
    assign wrap      = step && (idx == IW'(N_DIG - 1));
    assign upd_ready = ~pending;

    // A commit and a capture can never coincide: a commit needs a pending
    // value, which holds ready low. So a transfer landing on a wrap edge
    // finds nothing pending, becomes pending itself, and waits a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            disp_bcd   <= {N_DIG{4'hF}};
            disp_dp    <= '0;
            frame_tick <= 1'b0;
        end else begin
            presc      <= step ? '0 : presc + 1'b1;
            frame_tick <= wrap;
            if (step) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
            if (wrap && pending) begin
                disp_bcd <= pend_bcd;
                disp_dp  <= pend_dp;
                pending  <= 1'b0;
            end else if (upd_valid && !pending) begin
                pend_bcd <= upd_bcd;
                pend_dp  <= upd_dp;
                pending  <= 1'b1;
            end
        end
    end

    // Outputs come only from idx and the display register, so digit select
    // and pattern always move together on the same edge.
    assign an       = N_DIG'(1) << idx;
    assign cur_code = disp_bcd[int'(idx) * 4 +: 4];

    bcd_seg_dec u_dec (
        .code (cur_code),
        .segs (cur_segs)
    );

`ifdef DISPLAY_BLANK_LZ_EN
    // Walk down from the top digit; everything above the first nonzero
    // digit is a leading zero. Digit 0 is never blanked.
    always_comb begin
        logic seen;
        blank_lz = '0;
        seen     = 1'b0;
        for (int i = N_DIG - 1; i >= 1; i--) begin
            if (disp_bcd[i*4 +: 4] != 4'h0) begin
                seen = 1'b1;
            end
            blank_lz[i] = ~seen;
        end
    end
`else
    assign blank_lz = '0;
`endif

    assign seg = {(blank_lz[idx] ? 7'b0 : cur_segs), disp_dp[idx]};

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
// Directed bench for display_scan_ctrl with N_DIG=4, SCAN_DIV=4. Inputs are
// driven and outputs sampled 1 time unit after each rising edge; the
// comment "e=K" marks the state after the K-th edge since reset release.
// Leading-zero blanking expectations follow DISPLAY_BLANK_LZ_EN.
module tb_display_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_bcd;
    logic [3:0]  upd_dp;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

`ifdef DISPLAY_BLANK_LZ_EN
    localparam logic [7:0] ZERO_LZ    = 8'h00;
    localparam logic [7:0] ZERO_LZ_DP = 8'h01;
`else
    localparam logic [7:0] ZERO_LZ    = 8'hFC;
    localparam logic [7:0] ZERO_LZ_DP = 8'hFD;
`endif

    display_scan_ctrl #(
        .N_DIG    (4),
        .SCAN_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_bcd    (upd_bcd),
        .upd_dp     (upd_dp),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] bcd, input logic [3:0] dp);
        upd_valid = v;
        upd_bcd   = bcd;
        upd_dp    = dp;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg,
                              input logic exp_rdy, input logic exp_ft);
        checkOutput({tag, ".an"},    {4'h0, an},         {4'h0, exp_an});
        checkOutput({tag, ".seg"},   seg,                exp_seg);
        checkOutput({tag, ".ready"}, {7'h0, upd_ready},  {7'h0, exp_rdy});
        checkOutput({tag, ".ftick"}, {7'h0, frame_tick}, {7'h0, exp_ft});
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0000, 4'h0);
        tick(3);
        rst_n = 1'b1;
        checkState("reset", 4'b0001, 8'h00, 1'b1, 1'b0);

        // Scan stepping, e=4 and e=8
        tick(4);
        checkState("scan1", 4'b0010, 8'h00, 1'b1, 1'b0);
        tick(4);
        checkState("scan2", 4'b0100, 8'h00, 1'b1, 1'b0);

        // Offer 1234 mid-frame at e=9, captured on edge 10
        tick(1);
        applyStimulus(1'b1, 16'h1234, 4'b0100);
        tick(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        checkState("pend1", 4'b0100, 8'h00, 1'b0, 1'b0);

        // Second value offered while pending, held until ready returns
        tick(2);
        applyStimulus(1'b1, 16'h5678, 4'b0001);
        checkState("scan3", 4'b1000, 8'h00, 1'b0, 1'b0);
        tick(3);
        checkState("noTear", 4'b1000, 8'h00, 1'b0, 1'b0);

        // e=16 wrap: 1234 committed, held 5678 taken on edge 17
        tick(1);
        checkState("commit1", 4'b0001, 8'h66, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        checkState("pend2", 4'b0001, 8'h66, 1'b0, 1'b0);
        tick(3);
        checkState("d1_1234", 4'b0010, 8'hF2, 1'b0, 1'b0);
        tick(4);
        checkState("d2_1234", 4'b0100, 8'hDB, 1'b0, 1'b0);
        tick(4);
        checkState("d3_1234", 4'b1000, 8'h60, 1'b0, 1'b0);

        // e=32 wrap: 5678 with dp on digit 0
        tick(4);
        checkState("commit2", 4'b0001, 8'hFF, 1'b1, 1'b1);
        tick(4);
        checkState("d1_5678", 4'b0010, 8'hE0, 1'b1, 1'b0);

        // Transfer landing on wrap edge 48 waits a full frame
        tick(11);
        applyStimulus(1'b1, 16'h00A7, 4'b0000);
        tick(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        checkState("wrapXfer", 4'b0001, 8'hFF, 1'b0, 1'b1);
        tick(4);
        checkState("oldFrame", 4'b0010, 8'hE0, 1'b0, 1'b0);
        tick(12);
        checkState("commit3", 4'b0001, 8'hE0, 1'b1, 1'b1);
        tick(4);
        checkState("code10", 4'b0010, 8'h00, 1'b1, 1'b0);
        tick(4);
        checkState("d2_00A7", 4'b0100, ZERO_LZ, 1'b1, 1'b0);
        tick(4);
        checkState("d3_00A7", 4'b1000, ZERO_LZ, 1'b1, 1'b0);

        // 0007 with dp on digit 3, again transferred on a wrap edge (80)
        tick(3);
        applyStimulus(1'b1, 16'h0007, 4'b1000);
        tick(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        checkState("wrapXfer2", 4'b0001, 8'hE0, 1'b0, 1'b1);
        tick(16);
        checkState("commit4", 4'b0001, 8'hE0, 1'b1, 1'b1);
        tick(4);
        checkState("d1_0007", 4'b0010, ZERO_LZ, 1'b1, 1'b0);
        tick(4);
        checkState("d2_0007", 4'b0100, ZERO_LZ, 1'b1, 1'b0);
        tick(4);
        checkState("d3_0007", 4'b1000, ZERO_LZ_DP, 1'b1, 1'b0);

        // Reset with a value pending mid-frame discards it
        tick(2);
        applyStimulus(1'b1, 16'h9999, 4'b1111);
        tick(1);
        applyStimulus(1'b0, 16'h0000, 4'h0);
        checkState("pend3", 4'b1000, ZERO_LZ_DP, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checkState("midReset", 4'b0001, 8'h00, 1'b1, 1'b0);
        tick(15);
        checkState("postRst", 4'b1000, 8'h00, 1'b1, 1'b0);
        tick(1);
        checkState("lostPend", 4'b0001, 8'h00, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter N_DIG, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles each digit stays selected (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 upd_valid  input  1  new display value offered.
REQ-006 upd_ready  output  1  controller can accept a new value.
REQ-007 upd_bcd  input  4*N_DIG  BCD digits; digit 0 = bits [3:0], least significant.
REQ-008 upd_dp  input  N_DIG  decimal-point mask, bit i lights DP of digit i.
REQ-009 seg  output  8  segment pattern {a,b,c,d,e,f,g,dp}, bit 7 = a, active-high.
REQ-010 an  output  N_DIG  one-hot digit select, active-high.
REQ-011 frame_tick  output  1  one-cycle pulse at end of each full scan.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; digit index SHALL advance on the cycle the prescaler is at SCAN_DIV-1.
REQ-013 Digit index SHALL wrap N_DIG-1 -> 0; an SHALL equal 1<<index.
REQ-014 seg and an SHALL derive only from registered state so both change on the same edge.
REQ-015 Decode (bits 7..1): 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 (hex, bit 0 cleared); codes 10..15 SHALL give all segments off.
REQ-016 seg[0] SHALL equal the displayed DP mask bit of the selected digit, independent of the digit code.
REQ-017 Handshake: transfer when upd_valid and upd_ready high on a rising edge; upd_bcd/upd_dp captured into a pending buffer.
REQ-018 upd_ready SHALL be high exactly when no value is pending.
REQ-019 Pending value SHALL be committed to the display register only on the edge where index wraps N_DIG-1 -> 0 (no mid-frame tearing); pending then clears.
REQ-020 frame_tick SHALL be high for the one cycle following that wrap edge.
REQ-021 A transfer on the same edge as a wrap SHALL NOT commit that edge; it becomes pending and commits at the next wrap.
REQ-022 upd_valid while upd_ready low SHALL be ignored; the source holds data until ready.

Reset
REQ-023 While rst_n low at an edge: prescaler=0, index=0, pending cleared, display register all codes 4'hF, DP mask 0.
REQ-024 Hence after reset: an=one-hot digit 0, seg=8'h00, upd_ready=1, frame_tick=0.
REQ-025 Reset mid-frame or with a value pending SHALL discard the pending value.

Configuration
REQ-026 Macro DISPLAY_BLANK_LZ_EN defined: digits above the most significant nonzero digit SHALL show segments a..g off (DP still per mask); digit 0 always decoded.
REQ-027 Macro undefined: every digit decoded per REQ-015, zeros shown.

Structure
REQ-028 Package display_pkg SHALL hold the ten segment constants, SEG_BLANK, and the default N_DIG/SCAN_DIV constants.
REQ-029 One combinational sub-module bcd_seg_dec (4-bit code -> 7 segment bits) SHALL be instantiated once on the selected digit.

Verification (SCAN_DIV=4, N_DIG=4)
REQ-030 Release reset -> an=0001, seg=00, upd_ready=1; an steps 0010,0100,1000,0001 every 4 cycles.
REQ-031 Offer bcd=16'h1234, dp=4'b0100 mid-frame -> display unchanged until wrap; then digit0 seg=66, digit1 F2, digit2 DB, digit3 60; frame_tick one pulse.
REQ-032 Offer second value while pending -> upd_ready=0, value ignored until commit; held value accepted on first cycle ready returns.
REQ-033 Transfer on wrap edge -> displayed next frame, not current.
REQ-034 bcd=16'h00A7 -> digit1 shows 00 (code 10); with DISPLAY_BLANK_LZ_EN, 16'h0007 -> digits 3..1 seg=00, digit0 E0.
REQ-035 Assert rst_n low with value pending mid-frame -> next cycle REQ-024 state, pending lost.
